output_ram_scheduler: RTL and testbench

//  Sequences and shares the single-port 64-bit output RAM between the pixel-packing writer and the readout client.

---
 rtl/output_ram_scheduler.sv | 148 ++++++++++++++
 tb/tb_output_ram_scheduler.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_ram_scheduler.sv
// Output RAM scheduler: shares the single-port output RAM between the pixel
// packer (writer) and the readout client, tracks frame fill and grants reads.
//
// Request/grant handshake (both ports): a requester raises *_req together
// with its address/data and holds all of them unchanged until the
// combinational *_grant is seen high in the same cycle; a cycle with
// req=1 and grant=1 is the transfer. No request is queued internally.
module output_ram_scheduler #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 64,
    parameter int FRAME_WORDS  = 38400,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 frame_start,
    input  logic                                 wr_req,
    input  logic [ADDR_W-1:0]                    wr_addr,
    input  logic [DATA_W-1:0]                    wr_data,
    output logic                                 wr_grant,
    input  logic                                 rd_req,
    input  logic [ADDR_W-1:0]                    rd_addr,
    output logic                                 rd_grant,
    output logic [DATA_W-1:0]                    rd_data,
    output logic                                 rd_valid,
    output logic                                 ram_en,
    output logic                                 ram_we,
    output logic [ADDR_W-1:0]                    ram_addr,
    output logic [DATA_W-1:0]                    ram_din,
    input  logic [DATA_W-1:0]                    ram_dout,
    output logic                                 frame_done,
    output logic                                 frame_err,
    output logic [1:0]                           dbg_state,
    output logic [$clog2(FRAME_WORDS+1)-1:0]     dbg_wr_count
);

    localparam int CNT_W = $clog2(FRAME_WORDS + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   wr_count_q, wr_count_d;
    logic [STV_W-1:0]   starve_q, starve_d;
    logic               err_q, err_d;
    logic               rd_valid_q;
    logic               wr_grant_c;
    logic               rd_grant_c;
    logic               forced_rd;

    // State, counters and sticky error register; reset abandons any frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wr_count_q <= '0;
            starve_q   <= '0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_count_q <= wr_count_d;
            starve_q   <= starve_d;
            err_q      <= err_d;
            rd_valid_q <= rd_grant_c;
        end
    end

    // Next state, arbitration and frame counting.
    always_comb begin
        state_d    = state_q;
        wr_count_d = wr_count_q;
        starve_d   = '0;
        err_d      = err_q;
        wr_grant_c = 1'b0;
        rd_grant_c = 1'b0;
        forced_rd  = 1'b0;
        case (state_q)
            IDLE: begin
                rd_grant_c = rd_req;
                if (frame_start) begin
                    state_d    = FILL;
                    wr_count_d = '0;
                end
            end
            FILL: begin
                // Writer has priority until the reader has waited STARVE_LIMIT cycles.
                forced_rd = (starve_q == STV_W'(STARVE_LIMIT)) && rd_req;
                if (forced_rd) begin
                    rd_grant_c = 1'b1;
                end else begin
                    wr_grant_c = wr_req;
                    rd_grant_c = rd_req & ~wr_req;
                end
                if (rd_req && !rd_grant_c) begin
                    if (starve_q != STV_W'(STARVE_LIMIT)) begin
                        starve_d = starve_q + STV_W'(1);
                    end else begin
                        starve_d = starve_q;
                    end
                end
                if (wr_grant_c) begin
                    if (wr_count_q == CNT_W'(FRAME_WORDS - 1)) begin
                        state_d    = READY;
                        wr_count_d = '0;
                    end else begin
                        wr_count_d = wr_count_q + CNT_W'(1);
                    end
                end
                // A restart mid-fill is not honoured; it is only flagged.
                if (frame_start) begin
                    err_d = 1'b1;
                end
            end
            READY: begin
                rd_grant_c = rd_req;
                if (frame_start) begin
                    state_d    = FILL;
                    wr_count_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Grants are forced low while reset is asserted so nothing reaches the RAM.
    assign wr_grant     = wr_grant_c & reset_n;
    assign rd_grant     = rd_grant_c & reset_n;

    assign ram_en       = wr_grant | rd_grant;
    assign ram_we       = wr_grant;
    assign ram_addr     = wr_grant ? wr_addr : rd_addr;
    assign ram_din      = wr_data;

    assign rd_valid     = rd_valid_q;
    assign rd_data      = rd_valid_q ? ram_dout : '0;

    assign frame_done   = (state_q == READY);
    assign frame_err    = err_q;
    assign dbg_state    = state_q;
    assign dbg_wr_count = wr_count_q;

endmodule

// File: tb/tb_output_ram_scheduler.sv
// Directed testbench for output_ram_scheduler (FRAME_WORDS=4, STARVE_LIMIT=3).
module tb_output_ram_scheduler;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 64;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_READY = 2'd2;

    logic              clk;
    logic              reset_n;
    logic              frame_start;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_grant;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_grant;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;
    logic              frame_done;
    logic              frame_err;
    logic [1:0]        dbg_state;
    logic [2:0]        dbg_wr_count;

    logic [DATA_W-1:0] mem [16];
    logic [DATA_W-1:0] exp_mem [16];
    int total;
    int bad;

    output_ram_scheduler #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME_WORDS(4), .STARVE_LIMIT(3)
    ) dut (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_grant(wr_grant),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .frame_done(frame_done), .frame_err(frame_err),
        .dbg_state(dbg_state), .dbg_wr_count(dbg_wr_count)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM, 1-cycle read latency, 16 words deep.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr[3:0]] <= ram_din;
            else        ram_dout <= mem[ram_addr[3:0]];
        end
    end

    task automatic clear_inputs();
        frame_start = 1'b0;
        wr_req      = 1'b0;
        rd_req      = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_inputs();
        wr_req = 1'b1; rd_req = 1'b1; wr_addr = '0; rd_addr = '0; wr_data = '0;
        #2;
        total++; if (wr_grant !== 1'b0) begin bad++; $display("FAIL reset_wr_grant got=%0b exp=0", wr_grant); end
        total++; if (rd_grant !== 1'b0) begin bad++; $display("FAIL reset_rd_grant got=%0b exp=0", rd_grant); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%0b exp=0", rd_valid); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%0b exp=0", frame_done); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%0b exp=0", frame_err); end
        total++; if (dbg_state !== S_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
        total++; if (dbg_wr_count !== 3'd0) begin bad++; $display("FAIL reset_wr_count got=%0d exp=0", dbg_wr_count); end
        total++; if (rd_data !== 64'd0) begin bad++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        total++; if (wr_grant !== 1'b0) begin bad++; $display("FAIL idle_wr_grant got=%0b exp=0", wr_grant); end
        total++; if (rd_grant !== 1'b1) begin bad++; $display("FAIL idle_rd_grant got=%0b exp=1", rd_grant); end
        @(negedge clk);
        clear_inputs();
        #1;
        total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL idle_rd_valid got=%0b exp=1", rd_valid); end
    endtask

    task automatic test_fill();
        @(negedge clk);
        clear_inputs();
        frame_start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            frame_start = 1'b0;
            wr_req  = 1'b1;
            wr_addr = ADDR_W'(i);
            wr_data = 64'hA5A5_0000_0000_0000 | 64'(i);
            #1;
            total++; if (dbg_state !== S_FILL) begin bad++; $display("FAIL fill_state[%0d] got=%0d exp=1", i, dbg_state); end
            total++; if (wr_grant !== 1'b1) begin bad++; $display("FAIL fill_wr_grant[%0d] got=%0b exp=1", i, wr_grant); end
            total++; if (ram_we !== 1'b1) begin bad++; $display("FAIL fill_ram_we[%0d] got=%0b exp=1", i, ram_we); end
            total++; if (ram_addr !== ADDR_W'(i)) begin bad++; $display("FAIL fill_ram_addr[%0d] got=%0d exp=%0d", i, ram_addr, i); end
            total++; if (ram_din !== (64'hA5A5_0000_0000_0000 | 64'(i))) begin bad++; $display("FAIL fill_ram_din[%0d] got=%h", i, ram_din); end
            total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL fill_frame_done[%0d] got=%0b exp=0", i, frame_done); end
            exp_mem[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
        end
        @(negedge clk);
        wr_req = 1'b0;
        #1;
        total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL fill_done got=%0b exp=1", frame_done); end
        total++; if (dbg_state !== S_READY) begin bad++; $display("FAIL fill_ready_state got=%0d exp=2", dbg_state); end
        total++; if (dbg_wr_count !== 3'd0) begin bad++; $display("FAIL fill_count_clear got=%0d exp=0", dbg_wr_count); end
    endtask

    task automatic test_ready_read();
        @(negedge clk);
        wr_req = 1'b1; wr_addr = 16'd7; wr_data = 64'hDEAD_BEEF_0000_0007;
        rd_req = 1'b1; rd_addr = 16'd2;
        #1;
        total++; if (wr_grant !== 1'b0) begin bad++; $display("FAIL ready_wr_grant got=%0b exp=0", wr_grant); end
        total++; if (rd_grant !== 1'b1) begin bad++; $display("FAIL ready_rd_grant got=%0b exp=1", rd_grant); end
        total++; if (ram_addr !== 16'd2) begin bad++; $display("FAIL ready_ram_addr got=%0d exp=2", ram_addr); end
        total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL ready_ram_we got=%0b exp=0", ram_we); end
        @(negedge clk);
        clear_inputs();
        #1;
        total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL ready_rd_valid got=%0b exp=1", rd_valid); end
        total++; if (rd_data !== exp_mem[2]) begin bad++; $display("FAIL ready_rd_data got=%h exp=%h", rd_data, exp_mem[2]); end
        @(negedge clk);
        #1;
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL ready_rd_valid_drop got=%0b exp=0", rd_valid); end
        total++; if (rd_data !== 64'd0) begin bad++; $display("FAIL ready_rd_data_zero got=%h exp=0", rd_data); end
    endtask

    task automatic test_starve();
        logic exp_w;
        int w;
        w = 0;
        @(negedge clk);
        clear_inputs();
        frame_start = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            frame_start = 1'b0;
            wr_req  = 1'b1;
            wr_addr = ADDR_W'(4 + w);
            wr_data = 64'h5A5A_0000_0000_0000 | 64'(4 + w);
            rd_req  = 1'b1;
            rd_addr = 16'd1;
            exp_w   = (c != 3);
            #1;
            total++; if (wr_grant !== exp_w) begin bad++; $display("FAIL starve_wr_grant[%0d] got=%0b exp=%0b", c, wr_grant, exp_w); end
            total++; if (rd_grant !== !exp_w) begin bad++; $display("FAIL starve_rd_grant[%0d] got=%0b exp=%0b", c, rd_grant, !exp_w); end
            total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL starve_frame_done[%0d] got=%0b exp=0", c, frame_done); end
            if (c == 3) begin
                total++; if (ram_addr !== 16'd1) begin bad++; $display("FAIL starve_ram_addr got=%0d exp=1", ram_addr); end
            end
            if (c == 4) begin
                total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL starve_rd_valid got=%0b exp=1", rd_valid); end
                total++; if (rd_data !== exp_mem[1]) begin bad++; $display("FAIL starve_rd_data got=%h exp=%h", rd_data, exp_mem[1]); end
            end
            if (exp_w) begin
                exp_mem[4 + w] = 64'h5A5A_0000_0000_0000 | 64'(4 + w);
                w++;
            end
        end
        @(negedge clk);
        clear_inputs();
        #1;
        total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL starve_done got=%0b exp=1", frame_done); end
    endtask

    task automatic test_read_in_fill();
        @(negedge clk);
        clear_inputs();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        rd_req  = 1'b1;
        rd_addr = 16'd5;
        #1;
        total++; if (rd_grant !== 1'b1) begin bad++; $display("FAIL rdfill_rd_grant got=%0b exp=1", rd_grant); end
        total++; if (wr_grant !== 1'b0) begin bad++; $display("FAIL rdfill_wr_grant got=%0b exp=0", wr_grant); end
        total++; if (dbg_state !== S_FILL) begin bad++; $display("FAIL rdfill_state got=%0d exp=1", dbg_state); end
        @(negedge clk);
        clear_inputs();
        #1;
        total++; if (dbg_wr_count !== 3'd0) begin bad++; $display("FAIL rdfill_count got=%0d exp=0", dbg_wr_count); end
        total++; if (rd_data !== exp_mem[5]) begin bad++; $display("FAIL rdfill_rd_data got=%h exp=%h", rd_data, exp_mem[5]); end
    endtask

    task automatic test_frame_err();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            wr_req = 1'b1; wr_addr = ADDR_W'(8 + i); wr_data = 64'(8 + i);
            #1;
            total++; if (wr_grant !== 1'b1) begin bad++; $display("FAIL err_pre_wr_grant[%0d] got=%0b exp=1", i, wr_grant); end
        end
        @(negedge clk);
        wr_req = 1'b0;
        frame_start = 1'b1;
        #1;
        total++; if (dbg_wr_count !== 3'd2) begin bad++; $display("FAIL err_count_pre got=%0d exp=2", dbg_wr_count); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL err_pre got=%0b exp=0", frame_err); end
        @(negedge clk);
        frame_start = 1'b0;
        #1;
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL err_set got=%0b exp=1", frame_err); end
        total++; if (dbg_state !== S_FILL) begin bad++; $display("FAIL err_state got=%0d exp=1", dbg_state); end
        total++; if (dbg_wr_count !== 3'd2) begin bad++; $display("FAIL err_count_kept got=%0d exp=2", dbg_wr_count); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            wr_req = 1'b1; wr_addr = ADDR_W'(10 + i); wr_data = 64'(10 + i);
            #1;
            total++; if (wr_grant !== 1'b1) begin bad++; $display("FAIL err_post_wr_grant[%0d] got=%0b exp=1", i, wr_grant); end
            total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL err_post_done[%0d] got=%0b exp=0", i, frame_done); end
        end
        @(negedge clk);
        clear_inputs();
        #1;
        total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL err_done got=%0b exp=1", frame_done); end
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%0b exp=1", frame_err); end
    endtask

    task automatic test_reset_mid_fill();
        @(negedge clk);
        clear_inputs();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        rd_req = 1'b1; rd_addr = 16'd0;
        @(negedge clk);
        rd_req = 1'b0;
        wr_req = 1'b1; wr_addr = 16'd12; wr_data = 64'hBAD0_BAD0_BAD0_BAD0;
        #1;
        total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL mid_rd_valid_pre got=%0b exp=1", rd_valid); end
        total++; if (wr_grant !== 1'b1) begin bad++; $display("FAIL mid_wr_grant_pre got=%0b exp=1", wr_grant); end
        #1;
        reset_n = 1'b0;
        #1;
        total++; if (wr_grant !== 1'b0) begin bad++; $display("FAIL mid_wr_grant got=%0b exp=0", wr_grant); end
        total++; if (ram_en !== 1'b0) begin bad++; $display("FAIL mid_ram_en got=%0b exp=0", ram_en); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL mid_rd_valid got=%0b exp=0", rd_valid); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL mid_frame_err got=%0b exp=0", frame_err); end
        total++; if (dbg_state !== S_IDLE) begin bad++; $display("FAIL mid_state got=%0d exp=0", dbg_state); end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            total++; if (wr_grant !== 1'b0) begin bad++; $display("FAIL mid_post_wr_grant[%0d] got=%0b exp=0", i, wr_grant); end
            total++; if (dbg_state !== S_IDLE) begin bad++; $display("FAIL mid_post_state[%0d] got=%0d exp=0", i, dbg_state); end
        end
    endtask

    task automatic test_start_on_final();
        @(negedge clk);
        clear_inputs();
        frame_start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            frame_start = (i == 3);
            wr_req = 1'b1; wr_addr = ADDR_W'(12 + i); wr_data = 64'hC0DE_0000_0000_0000 | 64'(i);
            #1;
            total++; if (wr_grant !== 1'b1) begin bad++; $display("FAIL final_wr_grant[%0d] got=%0b exp=1", i, wr_grant); end
            total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL final_err_pre[%0d] got=%0b exp=0", i, frame_err); end
        end
        @(negedge clk);
        clear_inputs();
        #1;
        total++; if (dbg_state !== S_READY) begin bad++; $display("FAIL final_state got=%0d exp=2", dbg_state); end
        total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL final_done got=%0b exp=1", frame_done); end
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL final_err got=%0b exp=1", frame_err); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        ram_dout = '0;
        for (int i = 0; i < 16; i++) begin
            mem[i] = '0;
            exp_mem[i] = '0;
        end
        test_reset();
        test_fill();
        test_ready_read();
        test_starve();
        test_read_in_fill();
        test_frame_err();
        test_reset_mid_fill();
        test_start_on_final();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
